// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;

  localparam logic [2:0] OPC_NOP = 3'b000;
  localparam logic [2:0] OPC_CLR = 3'b110;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    CLEAR = 2'd3
  } state_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant; the pointer flips away from whoever was just served.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr_q, ptr_d;

  // Contested requests go to the pointer; a lone requester always wins.
  always_comb begin
    gnt   = req;
    ptr_d = ptr_q;
    if (req == 2'b11) begin
      gnt = ptr_q ? 2'b10 : 2'b01;
    end
    if (advance) begin
      ptr_d = ~gnt[1];
    end
  end

  // Pointer register, starts at requester 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto a dual-read-port memory with registered reads.
// Each accepted command occupies IDLE->ISSUE->WAIT; the response appears in WAIT.
// Optional whole-memory clear is enabled by defining MEM_ARB_CLEAR_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0]             req_we,
  input  logic [1:0][ADDR_W-1:0] req_addr_a,
  input  logic [1:0][ADDR_W-1:0] req_addr_b,
  input  logic [1:0][DATA_W-1:0] req_wdata,
  output logic [1:0]             rsp_valid,
  output logic [DATA_W-1:0]      rsp_data_a,
  output logic [DATA_W-1:0]      rsp_data_b,
  input  logic                   clr_req,
  output logic                   clr_done,
  output logic                   busy,
  output logic                   mem_we,
  output logic [2:0]             mem_opcode,
  output logic [ADDR_W-1:0]      mem_addr1,
  output logic [ADDR_W-1:0]      mem_addr2,
  output logic [DATA_W-1:0]      mem_data_in,
  input  logic [DATA_W-1:0]      mem_data_out1,
  input  logic [DATA_W-1:0]      mem_data_out2
);

  state_t              state_q, state_d;
  logic                cmd_id_q, cmd_id_d;
  logic                cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0]   cmd_addr_a_q, cmd_addr_a_d;
  logic [ADDR_W-1:0]   cmd_addr_b_q, cmd_addr_b_d;
  logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic [1:0]          gnt;
  logic                accept;
  logic                clr_take;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (accept),
    .gnt     (gnt)
  );

`ifdef MEM_ARB_CLEAR_EN
  logic clr_done_q, clr_done_d;

  assign clr_take = (state_q == IDLE) & clr_req;

  // Completion pulse lands in the IDLE cycle right after the clear opcode.
  always_comb begin
    clr_done_d = (state_q == CLEAR);
  end

  // Clear-done pulse register.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_done_q <= 1'b0;
    end else begin
      clr_done_q <= clr_done_d;
    end
  end

  assign clr_done = clr_done_q & ~rst;
`else
  logic unused_clr_req;

  assign unused_clr_req = clr_req;
  assign clr_take       = 1'b0;
  assign clr_done       = 1'b0;
`endif

  // Next state, command capture and all per-state outputs; reset masks outputs at once.
  always_comb begin
    state_d      = state_q;
    cmd_id_d     = cmd_id_q;
    cmd_we_d     = cmd_we_q;
    cmd_addr_a_d = cmd_addr_a_q;
    cmd_addr_b_d = cmd_addr_b_q;
    cmd_wdata_d  = cmd_wdata_q;
    accept       = 1'b0;
    req_ready    = 2'b00;
    rsp_valid    = 2'b00;
    mem_we       = 1'b0;
    mem_opcode   = OPC_NOP;
    case (state_q)
      IDLE: begin
        if (clr_take) begin
          state_d = CLEAR;
        end else begin
          req_ready = gnt;
          if (|(req_valid & gnt)) begin
            accept       = 1'b1;
            cmd_id_d     = gnt[1];
            cmd_we_d     = req_we[gnt[1]];
            cmd_addr_a_d = req_addr_a[gnt[1]];
            cmd_addr_b_d = req_addr_b[gnt[1]];
            cmd_wdata_d  = req_wdata[gnt[1]];
            state_d      = ISSUE;
          end
        end
      end
      ISSUE: begin
        mem_we  = cmd_we_q;
        state_d = WAIT;
      end
      WAIT: begin
        rsp_valid[cmd_id_q] = 1'b1;
        state_d             = IDLE;
      end
`ifdef MEM_ARB_CLEAR_EN
      CLEAR: begin
        mem_opcode = OPC_CLR;
        state_d    = IDLE;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
    if (rst) begin
      accept     = 1'b0;
      req_ready  = 2'b00;
      rsp_valid  = 2'b00;
      mem_we     = 1'b0;
      mem_opcode = OPC_NOP;
    end
  end

  // State and command registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cmd_id_q     <= 1'b0;
      cmd_we_q     <= 1'b0;
      cmd_addr_a_q <= '0;
      cmd_addr_b_q <= '0;
      cmd_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cmd_id_q     <= cmd_id_d;
      cmd_we_q     <= cmd_we_d;
      cmd_addr_a_q <= cmd_addr_a_d;
      cmd_addr_b_q <= cmd_addr_b_d;
      cmd_wdata_q  <= cmd_wdata_d;
    end
  end

  assign busy        = (state_q != IDLE) & ~rst;
  assign mem_addr1   = cmd_addr_a_q;
  assign mem_addr2   = cmd_addr_b_q;
  assign mem_data_in = cmd_wdata_q;
  assign rsp_data_a  = mem_data_out1;
  assign rsp_data_b  = mem_data_out2;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: timeline reference model plus response scoreboard.
// Build with MEM_ARB_CLEAR_EN defined to exercise the clear feature.
module tb_mem_arbiter;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
`ifdef MEM_ARB_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0]            req_we;
  logic [1:0][AW-1:0]    req_addr_a;
  logic [1:0][AW-1:0]    req_addr_b;
  logic [1:0][DW-1:0]    req_wdata;
  logic [1:0]            rsp_valid;
  logic [DW-1:0]         rsp_data_a;
  logic [DW-1:0]         rsp_data_b;
  logic                  clr_req;
  logic                  clr_done;
  logic                  busy;
  logic                  mem_we;
  logic [2:0]            mem_opcode;
  logic [AW-1:0]         mem_addr1;
  logic [AW-1:0]         mem_addr2;
  logic [DW-1:0]         mem_data_in;
  logic [DW-1:0]         mem_data_out1;
  logic [DW-1:0]         mem_data_out2;

  mem_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr_a    (req_addr_a),
    .req_addr_b    (req_addr_b),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_data_a    (rsp_data_a),
    .rsp_data_b    (rsp_data_b),
    .clr_req       (clr_req),
    .clr_done      (clr_done),
    .busy          (busy),
    .mem_we        (mem_we),
    .mem_opcode    (mem_opcode),
    .mem_addr1     (mem_addr1),
    .mem_addr2     (mem_addr2),
    .mem_data_in   (mem_data_in),
    .mem_data_out1 (mem_data_out1),
    .mem_data_out2 (mem_data_out2)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Memory behind the arbiter: registered read-before-write, whole-array clear opcode.
  logic          env_init;
  logic [DW-1:0] mem [DEPTH];

  always @(posedge clk) begin : memory
    mem_data_out1 <= mem[mem_addr1];
    mem_data_out2 <= mem[mem_addr2];
    if (env_init) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (mem_opcode == 3'b110) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (mem_we) begin
      mem[mem_addr1] <= mem_data_in;
    end
  end

  // Reference model: schedule of expected events keyed by cycle number.
  typedef struct {
    int            id;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    int            due;
  } rsp_t;

  rsp_t          sb[$];
  int            grant_log[$];
  logic [DW-1:0] ref_mem [DEPTH];
  int            free_at  = 0;
  int            we_at    = -1;
  int            clr_at   = -1;
  int            done_at  = -1;
  logic [AW-1:0] exp_waddr;
  logic [DW-1:0] exp_wdata;
  bit            ptr      = 1'b0;
  bit            rst_prev = 1'b1;
  int            acc_cnt [2];

  always @(negedge clk) begin : model
    logic [1:0] exp_ready;
    bit         idle;
    bit         take_clr;
    int         id;
    rsp_t       e;
    if (rst) begin
      check_output("rst_req_ready", req_ready, 0);
      check_output("rst_rsp_valid", rsp_valid, 0);
      check_output("rst_busy", busy, 0);
      check_output("rst_mem_we", mem_we, 0);
      check_output("rst_mem_opcode", mem_opcode, 0);
      check_output("rst_clr_done", clr_done, 0);
      sb.delete();
      free_at = cyc + 1;
      we_at   = -1;
      clr_at  = -1;
      done_at = -1;
      ptr     = 1'b0;
      if (env_init) foreach (ref_mem[k]) ref_mem[k] = '0;
    end else begin
      if (rst_prev) begin
        check_output("post_rst_mem_addr1", mem_addr1, 0);
        check_output("post_rst_mem_addr2", mem_addr2, 0);
        check_output("post_rst_mem_data_in", mem_data_in, 0);
      end
      idle      = (cyc >= free_at);
      take_clr  = CLR_EN && idle && clr_req;
      exp_ready = 2'b00;
      if (idle && !take_clr) begin
        exp_ready = (req_valid == 2'b11) ? (ptr ? 2'b10 : 2'b01) : req_valid;
      end
      check_output("req_ready", req_ready, exp_ready);
      check_output("busy", busy, !idle);
      check_output("mem_we", mem_we, cyc == we_at);
      check_output("mem_opcode", mem_opcode, (cyc == clr_at) ? 3'b110 : 3'b000);
      check_output("clr_done", clr_done, cyc == done_at);
      if (cyc == we_at) begin
        check_output("write_addr", mem_addr1, exp_waddr);
        check_output("write_data", mem_data_in, exp_wdata);
      end
      if (take_clr) begin
        clr_at  = cyc + 1;
        done_at = cyc + 2;
        free_at = cyc + 2;
        foreach (ref_mem[k]) ref_mem[k] = '0;
      end else if (exp_ready != 2'b00) begin
        id    = exp_ready[1] ? 1 : 0;
        e.id  = id;
        e.a   = ref_mem[req_addr_a[id]];
        e.b   = ref_mem[req_addr_b[id]];
        e.due = cyc + 2;
        sb.push_back(e);
        if (req_we[id]) begin
          ref_mem[req_addr_a[id]] = req_wdata[id];
          we_at     = cyc + 1;
          exp_waddr = req_addr_a[id];
          exp_wdata = req_wdata[id];
        end
        free_at = cyc + 3;
        ptr     = (id == 0);
        grant_log.push_back(id);
        acc_cnt[id]++;
      end
    end
    rst_prev = rst;
  end

  // Monitor: pops the scoreboard whenever a response is presented.
  int            rsp_count    = 0;
  int            done_count   = 0;
  int            clr_op_count = 0;
  logic [DW-1:0] last_rsp_a   = '0;

  always @(negedge clk) begin : monitor
    rsp_t e;
    if (!rst) begin
      if (clr_done) done_count++;
      if (mem_opcode == 3'b110) clr_op_count++;
      if (rsp_valid != 2'b00) begin
        rsp_count++;
        last_rsp_a = rsp_data_a;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL rsp_unexpected: got rsp_valid=%b, expected no response (cycle %0d)", rsp_valid, cyc);
        end else begin
          e = sb.pop_front();
          check_output("rsp_valid_id", rsp_valid, (e.id == 1) ? 2'b10 : 2'b01);
          check_output("rsp_data_a", rsp_data_a, e.a);
          check_output("rsp_data_b", rsp_data_b, e.b);
          check_output("rsp_latency", cyc, e.due);
        end
      end else if (sb.size() != 0 && sb[0].due < cyc) begin
        e = sb.pop_front();
        check_output("rsp_missing", rsp_valid, (e.id == 1) ? 2'b10 : 2'b01);
      end
    end
  end

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one command and holds it until the model records its handshake.
  task automatic apply_stimulus(input int i, input logic we, input logic [AW-1:0] a,
                                input logic [AW-1:0] b, input logic [DW-1:0] wd);
    int start;
    int budget;
    start         = acc_cnt[i];
    budget        = 60;
    req_we[i]     = we;
    req_addr_a[i] = a;
    req_addr_b[i] = b;
    req_wdata[i]  = wd;
    req_valid[i]  = 1'b1;
    do begin
      @(posedge clk);
      #1;
      budget--;
    end while (acc_cnt[i] == start && budget > 0);
    if (acc_cnt[i] == start) check_output("handshake_timeout", acc_cnt[i], start + 1);
    req_valid[i]  = 1'b0;
    req_we[i]     = 1'($urandom);
    req_addr_a[i] = AW'($urandom);
    req_addr_b[i] = AW'($urandom);
    req_wdata[i]  = DW'($urandom);
  endtask

  initial begin : stimulus
    int n0;
    int d0;
    int o0;
    rst        = 1'b1;
    env_init   = 1'b1;
    clr_req    = 1'b0;
    req_valid  = 2'b00;
    req_we     = 2'b00;
    req_addr_a = '0;
    req_addr_b = '0;
    req_wdata  = '0;
    idle_cycles(3);
    rst      = 1'b0;
    env_init = 1'b0;

    // Both requesters continuously valid from reset: grants must alternate 0,1,0,1...
    grant_log.delete();
    fork
      for (int n = 0; n < 4; n++) apply_stimulus(0, 1'b1, AW'(n), AW'(n), DW'(16'h1000 + n));
      for (int n = 0; n < 4; n++) apply_stimulus(1, 1'b1, AW'(8 + n), AW'(n), DW'(16'h2000 + n));
    join
    idle_cycles(3);
    check_output("alt_grant_count", grant_log.size(), 8);
    for (int k = 0; k < grant_log.size(); k++) check_output($sformatf("alt_grant_%0d", k), grant_log[k], k % 2);

    // Write then read back address 3.
    apply_stimulus(0, 1'b1, 4'd3, 4'd0, 16'hBEEF);
    apply_stimulus(0, 1'b0, 4'd3, 4'd0, 16'h0000);
    idle_cycles(3);
    check_output("beef_readback", last_rsp_a, 16'hBEEF);

    // Second write returns the first write's data.
    apply_stimulus(1, 1'b1, 4'd7, 4'd1, 16'h1234);
    apply_stimulus(0, 1'b1, 4'd7, 4'd2, 16'h5678);
    idle_cycles(3);
    check_output("write_old_data", last_rsp_a, 16'h1234);

    // Reset while waiting for the response aborts it.
    apply_stimulus(1, 1'b0, 4'd7, 4'd3, 16'h0000);
    @(posedge clk);
    #1;
    n0  = rsp_count;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycles(2);
    check_output("rst_abort_no_rsp", rsp_count, n0);
    apply_stimulus(1, 1'b0, 4'd7, 4'd3, 16'h0000);
    idle_cycles(3);
    check_output("post_rst_read", last_rsp_a, 16'h5678);
    check_output("post_rst_rsp_count", rsp_count, n0 + 1);

    d0 = done_count;
    o0 = clr_op_count;
`ifdef MEM_ARB_CLEAR_EN
    // Clear request wins over two waiting requesters, then they are served in pointer order.
    grant_log.delete();
    fork
      begin
        clr_req = 1'b1;
        @(posedge clk);
        #1;
        clr_req = 1'b0;
      end
      apply_stimulus(0, 1'b0, 4'd7, 4'd7, 16'h0000);
      apply_stimulus(1, 1'b0, 4'd3, 4'd3, 16'h0000);
    join
    idle_cycles(3);
    check_output("clr_done_count", done_count, d0 + 1);
    check_output("clr_op_count", clr_op_count, o0 + 1);
    check_output("clr_grant_count", grant_log.size(), 2);
    check_output("clr_grant_first", grant_log[0], 0);
    for (int k = 0; k < DEPTH; k++) apply_stimulus(k % 2, 1'b0, AW'(k), AW'(DEPTH - 1 - k), 16'h0000);
    idle_cycles(3);
    check_output("clr_last_read", last_rsp_a, 16'h0000);
`else
    // Clear request is ignored: no opcode, no done pulse, data kept.
    clr_req = 1'b1;
    idle_cycles(1);
    clr_req = 1'b0;
    idle_cycles(3);
    apply_stimulus(0, 1'b0, 4'd7, 4'd3, 16'h0000);
    idle_cycles(3);
    check_output("noclr_done_count", done_count, d0);
    check_output("noclr_op_count", clr_op_count, o0);
    check_output("noclr_data_kept", last_rsp_a, 16'h5678);
`endif

    // Randomized traffic with occasional clear requests.
    fork
      for (int n = 0; n < 25; n++) begin
        idle_cycles($urandom_range(0, 3));
        apply_stimulus(0, 1'($urandom), AW'($urandom), AW'($urandom), DW'($urandom));
      end
      for (int n = 0; n < 25; n++) begin
        idle_cycles($urandom_range(0, 3));
        apply_stimulus(1, 1'($urandom), AW'($urandom), AW'($urandom), DW'($urandom));
      end
      for (int n = 0; n < 6; n++) begin
        idle_cycles($urandom_range(5, 20));
        clr_req = 1'b1;
        idle_cycles(1);
        clr_req = 1'b0;
      end
    join
    idle_cycles(5);
    check_output("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the data word width.
REQ-002 Parameter ADDR_W, default 4, SHALL set the address width (2**ADDR_W words).
REQ-003 clk  input  1  SHALL be the single clock; all logic on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 req_valid[1:0]  input  2  SHALL carry the per-requester request valid.
REQ-006 req_ready[1:0]  output  2  SHALL carry the per-requester accept; at most one bit high.
REQ-007 req_we[1:0], req_addr_a[1:0][ADDR_W], req_addr_b[1:0][ADDR_W], req_wdata[1:0][DATA_W]  input  SHALL carry the per-requester command payload.
REQ-008 rsp_valid[1:0]  output  2  SHALL carry a one-cycle response pulse per requester.
REQ-009 rsp_data_a, rsp_data_b  output  DATA_W  SHALL carry the response data, shared between requesters.
REQ-010 clr_req  input  1  SHALL request a full memory clear; clr_done  output  1  SHALL pulse on completion.
REQ-011 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-012 mem_we  output  1, mem_opcode  output  3, mem_addr1/mem_addr2  output  ADDR_W, mem_data_in  output  DATA_W SHALL drive the memory; mem_data_out1/mem_data_out2  input  DATA_W SHALL return its registered read data.

Function
REQ-013 FSM states SHALL be IDLE, ISSUE, WAIT, CLEAR; reset state IDLE.
REQ-014 In IDLE, req_ready SHALL be asserted only for the granted valid requester; handshake = valid & ready at an edge.
REQ-015 With both requesters valid, the grant SHALL go to the priority pointer; after each grant the pointer SHALL point to the other requester.
REQ-016 With one requester valid, it SHALL be granted regardless of the pointer; the pointer still toggles away from it.
REQ-017 On handshake, the command SHALL be registered with a grant ID and the FSM SHALL go IDLE->ISSUE.
REQ-018 In ISSUE (acceptance cycle N+1), mem_addr1 = addr_a, mem_addr2 = addr_b, mem_data_in = wdata, mem_we = we; then ISSUE->WAIT.
REQ-019 In WAIT (N+2), rsp_valid[ID] SHALL be high for exactly one cycle with rsp_data_a/b = mem_data_out1/2 combinationally; then WAIT->IDLE.
REQ-020 Every accepted request SHALL yield exactly one response; for writes, rsp_data_a SHALL hold the pre-write contents of addr_a.
REQ-021 Minimum request-to-request spacing SHALL be 3 cycles; req_ready SHALL be 0 outside IDLE.
REQ-022 clr_req seen in IDLE SHALL take priority over both requesters: IDLE->CLEAR, no req_ready that cycle, pointer unchanged.
REQ-023 In CLEAR, mem_opcode SHALL be 3'b110 for one cycle with mem_we = 0; the next cycle is IDLE with clr_done high for one cycle.
REQ-024 Outside CLEAR, mem_opcode SHALL be 3'b000 and mem_we SHALL be 0 except in ISSUE for a write.
REQ-025 Requester payload SHALL be sampled only at handshake; later changes SHALL be ignored.

Reset
REQ-026 Under rst: state IDLE, pointer = requester 0, req_ready = 0, rsp_valid = 0, clr_done = 0, busy = 0, mem_we = 0, mem_opcode = 3'b000, data/address registers 0.
REQ-027 rst during ISSUE/WAIT/CLEAR SHALL abort the operation with no rsp_valid or clr_done; memory contents are not reset by this block.

Configuration
REQ-028 With MEM_ARB_CLEAR_EN defined, REQ-022/023 SHALL apply; without it, clr_req SHALL be ignored, clr_done tied 0, CLEAR unreachable, mem_opcode constant 3'b000.

Structure
REQ-029 Package mem_arb_pkg SHALL hold the state enum, OPC_NOP = 3'b000, OPC_CLR = 3'b110, and default widths.
REQ-030 Sub-module rr_arb2 (2-way round-robin grant plus pointer) SHALL implement REQ-015/016.

Verification
REQ-031 Req0 write addr_a = 3, wdata = 16'hBEEF, then read addr_a = 3, addr_b = 0 -> read rsp_data_a = 16'hBEEF in WAIT, 2 cycles after accept.
REQ-032 Both valid from reset, 4 requests each -> grants alternate 0,1,0,1,...; req_ready never 2'b11.
REQ-033 Write 16'h1234 then write 16'h5678 to addr 7 -> second write's rsp_data_a = 16'h1234.
REQ-034 clr_req with both requesters valid (MEM_ARB_CLEAR_EN) -> one mem_opcode = 3'b110 cycle, clr_done next cycle, all 16 words read back 0, grant order unaffected.
REQ-035 rst asserted in WAIT -> no rsp_valid, all outputs at reset values next cycle, next request served normally.
REQ-036 Without MEM_ARB_CLEAR_EN, clr_req pulsed -> clr_done stays 0, mem_opcode stays 3'b000, data preserved.
